// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants and width helper for the return address stack
package stack_pkg;

    localparam int MODE_SATURATE = 0;
    localparam int MODE_WRAP     = 1;

    // Never returns 0, so a DEPTH of 1 still yields a legal 1-bit vector.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH register array, sync write, async read
import stack_pkg::*;

module stack_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = clog2_safe(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - return address LIFO with status, replace-top and sticky errors
import stack_pkg::*;

module return_addr_stack #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = MODE_SATURATE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             err_clr,
    output logic [WIDTH-1:0]                 top,
    output logic [clog2_safe(DEPTH+1)-1:0]   count,
    output logic                             empty,
    output logic                             full,
    output logic                             overflow_err,
    output logic                             underflow_err
);

    localparam int PW = clog2_safe(DEPTH);
    localparam int CW = clog2_safe(DEPTH + 1);

    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_top;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rdata;
    logic             do_push;
    logic             do_pop;
    logic             do_rep;
    logic             push_ok;
    logic             we;
    logic [PW-1:0]    waddr;
    logic             ovf_set;
    logic             unf_set;

    assign sp_top  = sp - PW'(1);
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign top     = empty ? '0 : rdata;

    assign do_push = push & ~pop;
    assign do_pop  = pop & ~push;
    assign do_rep  = push & pop;

    // In wrap mode a push onto a full stack still advances sp, overwriting the oldest slot.
    assign push_ok = do_push & (~full | (WRAP_MODE == MODE_WRAP));

    // Replace-top on an empty stack degenerates to a plain push at sp.
    assign we      = rst_n & (push_ok | do_rep);
    assign waddr   = (do_rep & ~empty) ? sp_top : sp;

    assign ovf_set = do_push & full;
    assign unf_set = pop & empty;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (sp_top),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp            <= '0;
            cnt           <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push_ok || (do_rep && empty)) begin
                sp <= sp + PW'(1);
                if (!full) begin
                    cnt <= cnt + CW'(1);
                end
            end else if (do_pop && !empty) begin
                sp  <= sp_top;
                cnt <= cnt - CW'(1);
            end
            // A fresh error in the clearing cycle keeps its flag set.
            overflow_err  <= (overflow_err & ~err_clr) | ovf_set;
            underflow_err <= (underflow_err & ~err_clr) | unf_set;
        end
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - saturating and wrapping stacks checked against a queue model
import stack_pkg::*;

module tb_return_addr_stack;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic [11:0] push_data;
    logic        err_clr;

    logic [11:0] top_s, top_w;
    logic [3:0]  cnt_s, cnt_w;
    logic        empty_s, empty_w, full_s, full_w;
    logic        ovf_s, ovf_w, unf_s, unf_w;

    int checks = 0;
    int errors = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    bit          mo[2];
    bit          mu[2];

    return_addr_stack #(.WIDTH(12), .DEPTH(8), .WRAP_MODE(MODE_SATURATE)) dut_sat (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
        .err_clr(err_clr), .top(top_s), .count(cnt_s), .empty(empty_s), .full(full_s),
        .overflow_err(ovf_s), .underflow_err(unf_s)
    );

    return_addr_stack #(.WIDTH(12), .DEPTH(8), .WRAP_MODE(MODE_WRAP)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
        .err_clr(err_clr), .top(top_w), .count(cnt_w), .empty(empty_w), .full(full_w),
        .overflow_err(ovf_w), .underflow_err(unf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mo[0] = 0; mo[1] = 0; mu[0] = 0; mu[1] = 0;
    endtask

    task automatic model_apply(input int m, input bit pu, input bit po,
                               input logic [11:0] d, input bit clr);
        logic [11:0] q[$];
        bit o, u;
        if (m == 0) q = q0; else q = q1;
        o = mo[m] & !clr;
        u = mu[m] & !clr;
        if (pu && !po) begin
            if (q.size() == 8) begin
                o = 1;
                if (m == 1) begin
                    void'(q.pop_front());
                    q.push_back(d);
                end
            end else begin
                q.push_back(d);
            end
        end else if (po && !pu) begin
            if (q.size() == 0) u = 1;
            else void'(q.pop_back());
        end else if (pu && po) begin
            if (q.size() == 0) begin
                u = 1;
                q.push_back(d);
            end else begin
                q[q.size()-1] = d;
            end
        end
        if (m == 0) q0 = q; else q1 = q;
        mo[m] = o;
        mu[m] = u;
    endtask

    task automatic check_all(input string tag);
        logic [11:0] et;
        et = (q0.size() != 0) ? q0[q0.size()-1] : 12'h000;
        chk({tag, ".sat.top"},   32'(top_s),   32'(et));
        chk({tag, ".sat.count"}, 32'(cnt_s),   32'(q0.size()));
        chk({tag, ".sat.empty"}, 32'(empty_s), 32'(q0.size() == 0));
        chk({tag, ".sat.full"},  32'(full_s),  32'(q0.size() == 8));
        chk({tag, ".sat.ovf"},   32'(ovf_s),   32'(mo[0]));
        chk({tag, ".sat.unf"},   32'(unf_s),   32'(mu[0]));
        et = (q1.size() != 0) ? q1[q1.size()-1] : 12'h000;
        chk({tag, ".wrap.top"},   32'(top_w),   32'(et));
        chk({tag, ".wrap.count"}, 32'(cnt_w),   32'(q1.size()));
        chk({tag, ".wrap.empty"}, 32'(empty_w), 32'(q1.size() == 0));
        chk({tag, ".wrap.full"},  32'(full_w),  32'(q1.size() == 8));
        chk({tag, ".wrap.ovf"},   32'(ovf_w),   32'(mo[1]));
        chk({tag, ".wrap.unf"},   32'(unf_w),   32'(mu[1]));
    endtask

    task automatic step(input string tag, input bit pu, input bit po,
                        input logic [11:0] d, input bit clr);
        push = pu; pop = po; push_data = d; err_clr = clr;
        @(posedge clk);
        model_apply(0, pu, po, d, clr);
        model_apply(1, pu, po, d, clr);
        #1;
        push = 0; pop = 0; err_clr = 0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1; push = 0; pop = 0; push_data = '0; err_clr = 0;
        #2;
        do_reset();

        // Basic push/pop
        step("t1.push", 1, 0, 12'h100, 0);
        step("t1.push", 1, 0, 12'h104, 0);
        step("t1.push", 1, 0, 12'h108, 0);
        chk("t1.top3", 32'(top_s), 32'h108);
        chk("t1.cnt3", 32'(cnt_s), 32'd3);
        step("t1.pop", 0, 1, 12'h000, 0);
        chk("t1.top2", 32'(top_s), 32'h104);
        chk("t1.cnt2", 32'(cnt_s), 32'd2);

        // Overflow in both modes
        do_reset();
        for (int i = 1; i <= 8; i++) step("t2.fill", 1, 0, 12'(i), 0);
        step("t2.over", 1, 0, 12'hABC, 0);
        chk("t2.sat.top", 32'(top_s), 32'h008);
        chk("t2.sat.ovf", 32'(ovf_s), 32'd1);
        chk("t2.wrap.top", 32'(top_w), 32'hABC);

        // Wrap ordering after losing the oldest entry
        do_reset();
        for (int i = 1; i <= 9; i++) step("t3.fill", 1, 0, 12'(i), 0);
        chk("t3.wrap.top", 32'(top_w), 32'd9);
        chk("t3.wrap.cnt", 32'(cnt_w), 32'd8);
        for (int i = 9; i >= 2; i--) begin
            chk("t3.wrap.popval", 32'(top_w), 32'(i));
            step("t3.pop", 0, 1, 12'h000, 0);
        end
        chk("t3.wrap.empty", 32'(empty_w), 32'd1);
        chk("t3.wrap.unf", 32'(unf_w), 32'd0);

        // Underflow and clear
        step("t4.pop", 0, 1, 12'h000, 0);
        chk("t4.wrap.unf", 32'(unf_w), 32'd1);
        step("t4.clr", 0, 0, 12'h000, 1);
        chk("t4.wrap.unf_clr", 32'(unf_w), 32'd0);
        step("t4.clr_and_err", 0, 1, 12'h000, 1);

        // Replace top, including on empty
        do_reset();
        step("t5.push", 1, 0, 12'h010, 0);
        step("t5.push", 1, 0, 12'h020, 0);
        step("t5.rep", 1, 1, 12'h030, 0);
        chk("t5.rep.top", 32'(top_s), 32'h030);
        chk("t5.rep.cnt", 32'(cnt_s), 32'd2);
        step("t5.pop", 0, 1, 12'h000, 0);
        step("t5.pop", 0, 1, 12'h000, 0);
        step("t5.rep_empty", 1, 1, 12'h040, 1);
        chk("t5.rep_empty.top", 32'(top_s), 32'h040);
        chk("t5.rep_empty.unf", 32'(unf_s), 32'd1);
        for (int i = 0; i < 8; i++) step("t5.fill", 1, 0, 12'(12'h200 + i), 0);
        step("t5.rep_full", 1, 1, 12'h3FF, 1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step("t6.push", 1, 0, 12'(12'h050 + i), 0);
        push = 1; push_data = 12'h777;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("t6.async");
        @(posedge clk);
        #1;
        push = 0;
        check_all("t6.held");
        rst_n = 1;
        step("t6.after", 1, 0, 12'h055, 0);
        chk("t6.after.top", 32'(top_s), 32'h055);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                     12'($urandom), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
